// File: rtl/io_input_conditioner.sv
// rtl/io_input_conditioner.sv - synchronize and debounce switch/button pins onto io_input_bus
module io_input_conditioner #(
    parameter int SWITCH_WIDTH      = 10,
    parameter int BUTTON_WIDTH      = 4,
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int BUTTON_ACTIVE_LOW = 1
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [SWITCH_WIDTH-1:0]              switches_raw,
    input  logic [BUTTON_WIDTH-1:0]              buttons_raw,
    output logic [SWITCH_WIDTH+BUTTON_WIDTH-1:0] io_input_bus,
    output logic [BUTTON_WIDTH-1:0]              button_pressed
);

    localparam int N  = SWITCH_WIDTH + BUTTON_WIDTH;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [BUTTON_WIDTH-1:0] buttons_in;
    logic [N-1:0]            in_bits;
    logic [N-1:0]            sync1;
    logic [N-1:0]            sync2;
    logic [N-1:0]            stable;
    logic [N-1:0]            accept;
    logic [CW-1:0]           count [N];
    logic [BUTTON_WIDTH-1:0] pressed;

    // Inversion happens ahead of the synchronizer so every later stage is active-high.
    assign buttons_in = (BUTTON_ACTIVE_LOW != 0) ? ~buttons_raw : buttons_raw;
    assign in_bits    = {buttons_in, switches_raw};

    always_comb begin
        accept = '0;
        for (int i = 0; i < N; i++) begin
            accept[i] = (sync2[i] != stable[i]) && (count[i] == LAST);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1   <= '0;
            sync2   <= '0;
            stable  <= '0;
            pressed <= '0;
            for (int i = 0; i < N; i++) begin
                count[i] <= '0;
            end
        end else begin
            sync1 <= in_bits;
            sync2 <= sync1;
            for (int i = 0; i < N; i++) begin
                if (sync2[i] == stable[i]) begin
                    count[i] <= '0;
                end else if (accept[i]) begin
                    stable[i] <= sync2[i];
                    count[i]  <= '0;
                end else begin
                    count[i] <= count[i] + CW'(1);
                end
            end
            // Pulse only on an accepted rising transition of a button channel.
            pressed <= accept[N-1:SWITCH_WIDTH] & sync2[N-1:SWITCH_WIDTH];
        end
    end

    assign io_input_bus   = stable;
    assign button_pressed = pressed;

endmodule

// File: doc/io_input_conditioner.md
# io_input_conditioner

Conditions the board's raw switch and push-button pins into the 14-bit `io_input_bus` consumed by the data memory's memory-mapped I/O read port. Each pin gets a two-flop synchronizer and a per-bit debounce counter. Active-low buttons are converted to active-high. The block also emits a one-cycle press pulse per button for future interrupt or event logic. The block sits directly upstream of the data memory and is the only driver of `io_input_bus`.

## Interface
Parameters:
- `SWITCH_WIDTH`, 10, number of slide switches; maps to `io_input_bus[9:0]`.
- `BUTTON_WIDTH`, 4, number of push buttons; maps to `io_input_bus[13:10]`.
- `DEBOUNCE_CYCLES`, 500000, consecutive cycles a synchronized input must differ from its debounced value before the change is accepted. The default is 10 ms at 50 MHz. Legal range is ≥1.
- `BUTTON_ACTIVE_LOW`, 1, when 1 the raw button pins are inverted so that a pressed button reads as 1.

Ports:
- `clock`, in, 1, single system clock; all state updates on the rising edge.
- `reset`, in, 1, asynchronous, active-low reset.
- `switches_raw`, in, SWITCH_WIDTH, asynchronous switch pins.
- `buttons_raw`, in, BUTTON_WIDTH, asynchronous button pins, at raw pin polarity.
- `io_input_bus`, out, SWITCH_WIDTH+BUTTON_WIDTH, debounced values as `{buttons, switches}`, active-high.
- `button_pressed`, out, BUTTON_WIDTH, one-cycle pulse on each debounced button 0→1 transition.

## Operation
- Every input bit is processed by an independent, identical channel.
- Each channel holds four pieces of state:
  - `sync1`: first synchronizer flop.
  - `sync2`: second synchronizer flop.
  - `stable`: debounced value.
  - `count`: debounce counter, width $clog2(DEBOUNCE_CYCLES+1).
- Button channels apply the polarity inversion before `sync1` when BUTTON_ACTIVE_LOW=1. All downstream logic is therefore active-high.
- Per-edge channel update:
  - If `sync2 == stable`, then `count <= 0`.
  - Otherwise, if `count == DEBOUNCE_CYCLES-1`, then `stable <= sync2` and `count <= 0`.
  - Otherwise, `count <= count + 1`.
- `count` never exceeds DEBOUNCE_CYCLES-1, so it cannot wrap.
- Any return of `sync2` to `stable` before acceptance discards the partial count. Glitches shorter than DEBOUNCE_CYCLES cycles therefore never reach the output.
- `io_input_bus` is the concatenation of the `stable` bits with no extra logic. Bit 10 is button 0 and bit 13 is button 3.
- `button_pressed[i]` is a register set to 1 on the edge where button `stable[i]` goes 0→1. It is cleared on the following edge.
- Release transitions (1→0) produce no pulse.
- Reset:
  - Asserting `reset` (low) forces the following, independent of `clock`:
    - `sync1`, `sync2` and `stable` go to the inactive level (0 after inversion).
    - `count` goes to 0.
    - `io_input_bus` goes to 0 and `button_pressed` goes to 0.
  - A reset mid-debounce discards the partial count.
  - After release, a button already held down reads as a fresh press: the full latency applies and a pulse is emitted.

## Timing
- Let edge 0 be the first edge that samples a new raw level, held steady from then on.
- `sync2` shows the new level after edge 1.
- `stable` and `io_input_bus` update after edge DEBOUNCE_CYCLES+1.
- `button_pressed` pulses in the same cycle that `io_input_bus` updates.
- With DEBOUNCE_CYCLES=1, the block is a pure two-flop synchronizer: output updates after edge 2.
- Channels are fully independent. Simultaneous changes on several pins each resolve with the same latency.
- `io_input_bus` is a registered output with no combinational path from the raw pins. The data memory's registered read address can therefore sample it in any cycle.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and BUTTON_ACTIVE_LOW=1.
- **Reset values:** hold `reset`=0 with `buttons_raw`=4'b0000 (all pressed) → `io_input_bus`=0 and `button_pressed`=0 throughout, with no clock dependence.
- **Switch latency:** release reset; drive `switches_raw`=10'h2A5 before edge 0 → `io_input_bus[9:0]`=10'h2A5 exactly after edge 5, and not after edge 4.
- **Glitch rejection:** pulse `switches_raw[3]` high for 3 cycles, then low → `io_input_bus[3]` stays 0. A following 5-cycle high pulse → bit goes to 1 after the 5th edge from its start.
- **Button press pulse:** drive `buttons_raw[2]`=0 → `io_input_bus[12]`=1 after edge 5; `button_pressed`=4'b0100 for exactly one cycle. Releasing the button → bit clears after 5 edges with no pulse.
- **Bounce train:** toggle `buttons_raw[0]` every 2 cycles for 20 cycles, then hold it low → exactly one `button_pressed[0]` pulse, 5 edges after the final hold begins.
- **Reset mid-debounce:** change `switches_raw[0]` to 1, then assert `reset` after 3 edges and release it → `io_input_bus[0]`=0 during reset, then becomes 1 a full 5 edges after release.
